// File: rtl/aes_uart_pkg.sv
// Shared constants and state type for the AES UART byte-serial transmit/receive paths.
// Ports: none (package only).
// Latency/backpressure: not applicable.
package aes_uart_pkg;

  localparam int AES_BLOCK_BITS = 128;
  localparam int BYTE_W         = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    FLUSH   = 1'b1
  } rx_state_t;

endpackage

// File: rtl/rx_shift_if.sv
// Byte-in / block-out bundle between the UART receiver, rx_shift and the AES input buffer.
// Ports: rx_done/rx_data (byte strobe + byte), buffer_full (downstream stall),
//        buffer_write/dout/shift_done (block write), overrun/timeout (error pulses).
interface rx_shift_if #(
  parameter int BLOCK_W = aes_uart_pkg::AES_BLOCK_BITS
);
  import aes_uart_pkg::*;

  logic               rx_done;
  logic [BYTE_W-1:0]  rx_data;
  logic               buffer_full;
  logic               buffer_write;
  logic [BLOCK_W-1:0] dout;
  logic               shift_done;
  logic               overrun;
  logic               timeout;

  // master: the environment supplying bytes and the buffer stall
  modport master (
    output rx_done, rx_data, buffer_full,
    input  buffer_write, dout, shift_done, overrun, timeout
  );

  // slave: the block assembler
  modport slave (
    input  rx_done, rx_data, buffer_full,
    output buffer_write, dout, shift_done, overrun, timeout
  );

endinterface

// File: rtl/rx_idle_timer.sv
// Idle counter between bytes of a partial block; expired pulses on the cycle the count reaches TIMEOUT_CYCLES.
// Ports: clk, reset (async active-low), clear (zero the count), enable (count this cycle), expired.
// Latency: expired is combinational from the count; TIMEOUT_CYCLES=0 disables it.
module rx_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Expiry fires as the count steps from TIMEOUT_CYCLES-1 to TIMEOUT_CYCLES, so the
  // pulse lands on the TIMEOUT_CYCLES-th idle cycle rather than one later.
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  assign expired = (TIMEOUT_CYCLES != 0) && enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || expired) begin
      cnt <= '0;
    end else if (enable && (cnt != SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rx_shift.sv
// Assembles BYTES received bytes (first byte in the MSBs) into one block and writes it to the AES input buffer.
// Ports: clk, reset (async active-low), bus (rx_shift_if.slave: byte in, block write out, error pulses).
// Latency: write strobe one cycle after the last byte; while buffer_full the block is held and new bytes are dropped (overrun).
module rx_shift
  import aes_uart_pkg::*;
#(
  parameter int BYTES          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic      clk,
  input  logic      reset,
  rx_shift_if.slave bus
);

  localparam int CTR_W = $clog2(BYTES);
  localparam int BLK_W = BYTES * BYTE_W;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(BYTES - 1);

  rx_state_t        state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [BLK_W-1:0] data_q, data_d, shifted;
  logic [BLK_W-1:0] dout_q, dout_d;
  logic             write_q, write_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             idle_clear, idle_enable, expired;

  // Idle time only matters while a partial block is being collected.
  assign idle_enable = (state_q == COLLECT) && (ctr_q != '0);
  assign idle_clear  = bus.rx_done || !idle_enable;

  rx_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle_clear),
    .enable (idle_enable),
    .expired(expired)
  );

  assign shifted = {data_q[BLK_W-BYTE_W-1:0], bus.rx_data};

  // State register together with the datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= COLLECT;
      ctr_q     <= '0;
      data_q    <= '0;
      dout_q    <= '0;
      write_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      data_q    <= data_d;
      dout_q    <= dout_d;
      write_q   <= write_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state, byte counter and shift register.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    data_d  = data_q;
    case (state_q)
      COLLECT: begin
        if (bus.rx_done) begin
          data_d = shifted;
          if (ctr_q == CTR_LAST) begin
            ctr_d   = '0;
            state_d = FLUSH;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end else if (expired) begin
          ctr_d = '0;
        end
      end
      FLUSH: begin
        if (!bus.buffer_full) begin
          state_d = COLLECT;
          // A byte arriving alongside the write starts the next block; dout
          // takes the old data_q so shifting now does not disturb it.
          if (bus.rx_done) begin
            data_d = shifted;
            ctr_d  = CTR_W'(1);
          end
        end
      end
      default: begin
        state_d = COLLECT;
        ctr_d   = '0;
      end
    endcase
  end

  // Output pulses and block register.
  always_comb begin
    write_d   = (state_q == FLUSH) && !bus.buffer_full;
    overrun_d = (state_q == FLUSH) && bus.buffer_full && bus.rx_done;
    timeout_d = expired && !bus.rx_done;
    dout_d    = write_d ? data_q : dout_q;
  end

  assign bus.buffer_write = write_q;
  assign bus.shift_done   = write_q;
  assign bus.dout         = dout_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_rx_shift.sv
// Bench for rx_shift: directed scenarios plus random byte/stall/idle traffic scored against a byte-queue model.
// Ports: none (top-level bench).
// Timing: inputs change after the falling edge, outputs are sampled on the falling edge.
module tb_rx_shift;
  import aes_uart_pkg::*;

  localparam int TO = 50;
  localparam logic [127:0] BLK_LO = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BLK_HI = 128'h101112131415161718191A1B1C1D1E1F;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rx_shift_if bus ();

  rx_shift #(
    .BYTES         (16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: bytes of the block being collected, plus one completed block awaiting the buffer.
  logic [7:0]   q[$];
  bit           pend = 0;
  logic [127:0] pend_blk = '0;
  logic [127:0] e_dout = '0;
  int           idle = 0;
  bit           e_wr = 0, e_ov = 0, e_to = 0;

  // Scenario observations.
  int           cycno = 0;
  int           n_wr = 0, n_ov = 0, n_to = 0, to_cyc = -1;
  logic [127:0] wq[$];

  function automatic logic [127:0] pack_q();
    logic [127:0] b = '0;
    foreach (q[i]) b = (b << 8) | 128'(q[i]);
    return b;
  endfunction

  task automatic model_step(input bit rd, input logic [7:0] d, input bit full);
    e_wr = 0; e_ov = 0; e_to = 0;
    if (pend) begin
      if (!full) begin
        e_wr = 1;
        e_dout = pend_blk;
        pend = 0;
        if (rd) begin q.push_back(d); idle = 0; end
      end else if (rd) begin
        e_ov = 1;
      end
    end else if (rd) begin
      q.push_back(d);
      idle = 0;
      if (q.size() == 16) begin
        pend_blk = pack_q();
        q.delete();
        pend = 1;
      end
    end else if (q.size() > 0) begin
      idle++;
      if (idle == TO) begin
        q.delete();
        idle = 0;
        e_to = 1;
      end
    end
  endtask

  task automatic cyc(input bit rd, input logic [7:0] d, input bit full);
    bus.rx_done = rd;
    bus.rx_data = d;
    bus.buffer_full = full;
    @(posedge clk);
    model_step(rd, d, full);
    @(negedge clk);
    cycno++;
    check("buffer_write", 128'(bus.buffer_write), 128'(e_wr));
    check("shift_done",   128'(bus.shift_done),   128'(e_wr));
    check("overrun",      128'(bus.overrun),      128'(e_ov));
    check("timeout",      128'(bus.timeout),      128'(e_to));
    check("dout",         bus.dout,               e_dout);
    if (bus.buffer_write) begin n_wr++; wq.push_back(bus.dout); end
    if (bus.overrun) n_ov++;
    if (bus.timeout) begin n_to++; to_cyc = cycno; end
  endtask

  task automatic clr_obs();
    n_wr = 0; n_ov = 0; n_to = 0; to_cyc = -1;
    wq.delete();
  endtask

  // Asynchronous reset pulse in the middle of a low clock phase.
  task automatic do_reset();
    bus.rx_done = 1'b0;
    bus.buffer_full = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_write",   128'(bus.buffer_write), 128'(0));
    check("rst_done",    128'(bus.shift_done),   128'(0));
    check("rst_overrun", 128'(bus.overrun),      128'(0));
    check("rst_timeout", 128'(bus.timeout),      128'(0));
    check("rst_dout",    bus.dout,               128'(0));
    q.delete(); pend = 0; idle = 0; e_dout = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_spaced(input int first, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      cyc(1'b1, 8'(first + i), 1'b0);
      repeat (9) cyc(1'b0, 8'h00, 1'b0);
    end
  endtask

  initial begin
    int start;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.buffer_full = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("init_write",   128'(bus.buffer_write), 128'(0));
    check("init_timeout", 128'(bus.timeout),      128'(0));
    check("init_dout",    bus.dout,               128'(0));
    reset = 1'b1;

    // 1: spaced bytes 00..0F, no stall.
    clr_obs();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 15) start = cycno;
      repeat (9) cyc(1'b0, 8'h00, 1'b0);
    end
    check("s1_nwrites", 128'(n_wr), 128'(1));
    check("s1_block", wq.size() > 0 ? wq[0] : 'x, BLK_LO);

    // 2: stall 5 cycles after the 16th byte, AA arrives while stalled.
    clr_obs();
    send_spaced(0, 15);
    cyc(1'b1, 8'h0F, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hAA, 1'b1);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    check("s2_nowrite_stalled", 128'(n_wr), 128'(0));
    cyc(1'b0, 8'h00, 1'b0);
    check("s2_write_on_release", 128'(n_wr), 128'(1));
    repeat (5) cyc(1'b0, 8'h00, 1'b0);
    send_spaced(0, 16);
    check("s2_overruns", 128'(n_ov), 128'(1));
    check("s2_nwrites", 128'(n_wr), 128'(2));
    check("s2_block0", wq.size() > 0 ? wq[0] : 'x, BLK_LO);
    check("s2_block1", wq.size() > 1 ? wq[1] : 'x, BLK_LO);

    // 3: 32 back-to-back bytes.
    clr_obs();
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(i), 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    check("s3_nwrites", 128'(n_wr), 128'(2));
    check("s3_block0", wq.size() > 0 ? wq[0] : 'x, BLK_LO);
    check("s3_block1", wq.size() > 1 ? wq[1] : 'x, BLK_HI);
    check("s3_overruns", 128'(n_ov), 128'(0));

    // 4: partial block times out after TO idle cycles.
    clr_obs();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
    start = cycno;
    repeat (TO + 5) cyc(1'b0, 8'h00, 1'b0);
    check("s4_ntimeouts", 128'(n_to), 128'(1));
    check("s4_timeout_cycle", 128'(to_cyc - start), 128'(TO));
    check("s4_nowrite", 128'(n_wr), 128'(0));
    send_spaced(0, 16);
    check("s4_block", wq.size() > 0 ? wq[0] : 'x, BLK_LO);

    // 5: reset after 9 bytes.
    clr_obs();
    send_spaced(16, 9);
    do_reset();
    check("s5_nowrite", 128'(n_wr), 128'(0));
    send_spaced(0, 16);
    check("s5_nwrites", 128'(n_wr), 128'(1));
    check("s5_block", wq.size() > 0 ? wq[0] : 'x, BLK_LO);

    // 6: long idle with nothing collected.
    clr_obs();
    repeat (300) cyc(1'b0, 8'h00, 1'b0);
    check("s6_ntimeouts", 128'(n_to), 128'(0));
    check("s6_nwrites", 128'(n_wr), 128'(0));

    // Random traffic: varying byte density and stall rate, idle gaps, occasional reset.
    for (int seg = 0; seg < 40; seg++) begin
      int p_rd, p_full, len;
      p_rd   = $urandom_range(5, 100);
      p_full = $urandom_range(0, 70);
      len    = $urandom_range(20, 120);
      for (int k = 0; k < len; k++)
        cyc($urandom_range(0, 99) < p_rd, 8'($urandom), $urandom_range(0, 99) < p_full);
      case ($urandom_range(0, 5))
        0: repeat (TO + $urandom_range(0, 10)) cyc(1'b0, 8'h00, 1'b0);
        1: repeat (TO - 1) cyc(1'b0, 8'h00, 1'b0);
        2: do_reset();
        default: ;
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
